// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_pkg                                                      |
// | Description : Shared types, constants and helpers for the BCD counter.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } bcd_cnt_state_e;

    function automatic bcd_digit_t bcd_to_gray_nib(input bcd_digit_t d);
        return d ^ (d >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_digit_cell                                               |
// | Description : One mod-10 decade with load, increment and decrement.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  bcd_digit_t din,
    output bcd_digit_t q,
    output logic       carry,
    output logic       borrow
);

    bcd_digit_t r_q;

    assign q      = r_q;
    assign carry  = inc && (r_q == BCD_MAX);
    assign borrow = dec && (r_q == 4'd0);

    // An illegal load digit lands as 0 so no downstream stage ever sees it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 4'd0;
        end else if (load) begin
            r_q <= (din > BCD_MAX) ? 4'd0 : din;
        end else if (inc) begin
            r_q <= carry ? 4'd0 : r_q + 4'd1;
        end else if (dec) begin
            r_q <= borrow ? BCD_MAX : r_q - 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_counter_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_counter_stage                                            |
// | Description : Multi-digit BCD up/down counter with valid/ready output.     |
// |               Define BCD_CNT_GRAY_OUT_EN to add the out_gray port.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_counter_stage
    import bcd_pkg::*;
#(
    parameter int DIGITS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                dir,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    output logic                load_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_tc,
`ifdef BCD_CNT_GRAY_OUT_EN
    output logic [4*DIGITS-1:0] out_gray,
`endif
    output logic                err
);

    bcd_cnt_state_e r_state;
    bcd_cnt_state_e w_state_next;

    logic                r_tc;
    logic                r_err;
    logic                w_hold;
    logic                w_hs;
    logic                w_load;
    logic                w_step_up;
    logic                w_step_dn;
    logic [4*DIGITS-1:0] w_count;
    logic [DIGITS-1:0]   w_inc;
    logic [DIGITS-1:0]   w_dec;
    logic [DIGITS-1:0]   w_carry;
    logic [DIGITS-1:0]   w_borrow;

    logic w_cur9, w_cur0, w_hi9, w_hi0, w_ld9, w_ld0, w_ld_bad;
    logic w_next9, w_next0;

    assign w_hold     = out_valid && !out_ready;
    assign w_hs       = out_valid && out_ready;
    assign w_load     = load && !w_hold;
    assign w_step_up  = w_hs && !w_load && dir;
    assign w_step_dn  = w_hs && !w_load && !dir;
    assign load_ready = !w_hold;
    assign out_bcd    = w_count;
    assign err        = r_err;

    assign w_inc[0] = w_step_up;
    assign w_dec[0] = w_step_dn;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk    (clk),
            .reset  (reset),
            .inc    (w_inc[gi]),
            .dec    (w_dec[gi]),
            .load   (w_load),
            .din    (load_value[4*gi +: 4]),
            .q      (w_count[4*gi +: 4]),
            .carry  (w_carry[gi]),
            .borrow (w_borrow[gi])
        );
        if (gi > 0) begin : g_chain
            assign w_inc[gi] = w_carry[gi-1];
            assign w_dec[gi] = w_borrow[gi-1];
        end
    end

`ifdef BCD_CNT_GRAY_OUT_EN
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_gray
        assign out_gray[4*gi +: 4] = bcd_to_gray_nib(w_count[4*gi +: 4]);
    end
`endif

    // Word-level flags on the current count and on the (sanitised) load word.
    always_comb begin
        w_cur9   = 1'b1;
        w_cur0   = 1'b1;
        w_hi9    = 1'b1;
        w_hi0    = 1'b1;
        w_ld9    = 1'b1;
        w_ld0    = 1'b1;
        w_ld_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_count[4*i +: 4] != BCD_MAX) w_cur9 = 1'b0;
            if (w_count[4*i +: 4] != 4'd0)    w_cur0 = 1'b0;
            if (i > 0 && w_count[4*i +: 4] != BCD_MAX) w_hi9 = 1'b0;
            if (i > 0 && w_count[4*i +: 4] != 4'd0)    w_hi0 = 1'b0;
            if (load_value[4*i +: 4] > BCD_MAX)  w_ld_bad = 1'b1;
            if (load_value[4*i +: 4] != BCD_MAX) w_ld9 = 1'b0;
            if (load_value[4*i +: 4] != 4'd0 && load_value[4*i +: 4] <= BCD_MAX) w_ld0 = 1'b0;
        end
    end

    // Terminal-count lookahead: predicts whether the word after this edge is
    // all-9s / all-0s, so out_tc is a true flop aligned with out_bcd.
    always_comb begin
        w_next9 = w_cur9;
        w_next0 = w_cur0;
        if (w_load) begin
            w_next9 = w_ld9;
            w_next0 = w_ld0;
        end else if (w_step_up) begin
            w_next9 = w_hi9 && (w_count[3:0] == 4'd8);
            w_next0 = w_carry[DIGITS-1];
        end else if (w_step_dn) begin
            w_next9 = w_borrow[DIGITS-1];
            w_next0 = w_hi0 && (w_count[3:0] == 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tc  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (!w_hold) begin
                r_tc <= (dir && w_next9) || (!dir && w_next0);
            end
            if (w_load && w_ld_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (en) w_state_next = EMIT;
            EMIT:    if (out_ready && !en) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == EMIT);
        out_tc    = out_valid && r_tc;
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bcd_counter_stage                                         |
// | Description : Self-checking bench for bcd_counter_stage (DIGITS = 2).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bcd_counter_stage;

    localparam int DIGITS = 2;
    localparam int MOD    = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic       out_ready = 1'b0;
    logic       load_ready;
    logic       out_valid;
    logic [7:0] out_bcd;
    logic       out_tc;
    logic       err;
`ifdef BCD_CNT_GRAY_OUT_EN
    logic [7:0] out_gray;
    logic [3:0] gray_tab [10] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD};
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_counter_stage #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .load_ready (load_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bcd    (out_bcd),
        .out_tc     (out_tc),
`ifdef BCD_CNT_GRAY_OUT_EN
        .out_gray   (out_gray),
`endif
        .err        (err)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        int t;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference model: the count is a plain integer modulo 10^DIGITS.
    int m_val   = 0;
    bit m_valid = 1'b0;
    bit m_tc    = 1'b0;
    bit m_err   = 1'b0;
    bit m_live  = 1'b0;

    always @(posedge clk) begin : model
        automatic int nv;
        automatic int d;
        automatic bit hold;
        automatic bit hs;
        automatic bit nerr;
        if (reset) begin
            m_val   <= 0;
            m_valid <= 1'b0;
            m_tc    <= 1'b0;
            m_err   <= 1'b0;
            m_live  <= 1'b1;
        end else begin
            hold = m_valid && !out_ready;
            hs   = m_valid && out_ready;
            nv   = m_val;
            nerr = m_err;
            if (load && !hold) begin
                nv = 0;
                for (int i = DIGITS - 1; i >= 0; i--) begin
                    d = int'(load_value[4*i +: 4]);
                    if (d > 9) begin
                        d    = 0;
                        nerr = 1'b1;
                    end
                    nv = nv * 10 + d;
                end
            end else if (hs) begin
                nv = dir ? (m_val + 1) % MOD : (m_val + MOD - 1) % MOD;
            end
            if (!hold) m_tc <= dir ? (nv == MOD - 1) : (nv == 0);
            m_val <= nv;
            m_err <= nerr;
            if (!m_valid)          m_valid <= en;
            else if (hs && !en)    m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        if (m_live) begin
            chk("out_valid",  {31'd0, out_valid},  {31'd0, m_valid});
            chk("out_bcd",    {24'd0, out_bcd},    {24'd0, to_bcd(m_val)});
            chk("out_tc",     {31'd0, out_tc},     {31'd0, m_valid && m_tc});
            chk("err",        {31'd0, err},        {31'd0, m_err});
            chk("load_ready", {31'd0, load_ready}, {31'd0, !(m_valid && !out_ready)});
`ifdef BCD_CNT_GRAY_OUT_EN
            begin
                automatic logic [7:0] b = to_bcd(m_val);
                chk("out_gray", {24'd0, out_gray},
                    {24'd0, b[7:4] ^ (b[7:4] >> 1), b[3:0] ^ (b[3:0] >> 1)});
            end
`endif
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_bcd",   {24'd0, out_bcd},   32'h00);
        chk("rst_tc",    {31'd0, out_tc},    32'd0);
        chk("rst_err",   {31'd0, err},       32'd0);

        // Count up through the full range and wrap.
        en = 1'b1; dir = 1'b1; out_ready = 1'b1;
        tick();
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        chk("first_bcd",   {24'd0, out_bcd},   32'h00);
        tick(99);
        chk("up_99",    {24'd0, out_bcd}, 32'h99);
        chk("up_99_tc", {31'd0, out_tc},  32'd1);
        tick();
        chk("wrap_00",    {24'd0, out_bcd}, 32'h00);
        chk("wrap_00_tc", {31'd0, out_tc},  32'd0);

        // Load zero and count down through the wrap.
        load = 1'b1; load_value = 8'h00; dir = 1'b0;
        tick();
        load = 1'b0;
        chk("dn_00",    {24'd0, out_bcd}, 32'h00);
        chk("dn_00_tc", {31'd0, out_tc},  32'd1);
        tick();
        chk("dn_99",    {24'd0, out_bcd}, 32'h99);
        chk("dn_99_tc", {31'd0, out_tc},  32'd0);
        tick();
        chk("dn_98",    {24'd0, out_bcd}, 32'h98);

        // Backpressure hold at 37; a load during the hold is ignored.
        load = 1'b1; load_value = 8'h37; dir = 1'b1;
        tick();
        load = 1'b0; out_ready = 1'b0;
        chk("hold_37", {24'd0, out_bcd}, 32'h37);
        tick();
        chk("hold_lr", {31'd0, load_ready}, 32'd0);
        load = 1'b1; load_value = 8'h55;
        tick();
        load = 1'b0;
        chk("hold_ign", {24'd0, out_bcd}, 32'h37);
        tick();
        chk("hold_3", {24'd0, out_bcd}, 32'h37);
        out_ready = 1'b1;
        #1;
        chk("lr_comb", {31'd0, load_ready}, 32'd1);
        tick();
        chk("after_hold", {24'd0, out_bcd}, 32'h38);

        // Illegal digit load, then load beating a simultaneous step.
        load = 1'b1; load_value = 8'hA5;
        tick();
        chk("bad_ld", {24'd0, out_bcd}, 32'h05);
        chk("err_set", {31'd0, err}, 32'd1);
        load_value = 8'h42;
        tick();
        load = 1'b0;
        chk("ld_prio", {24'd0, out_bcd}, 32'h42);
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Reset mid-beat drops the beat.
        load = 1'b1; load_value = 8'h63;
        tick();
        load = 1'b0; out_ready = 1'b0;
        chk("pre_rst", {24'd0, out_bcd}, 32'h63);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_bcd",   {24'd0, out_bcd},   32'h00);
        chk("mid_rst_err",   {31'd0, err},       32'd0);
        reset = 1'b0;
        tick();
        chk("re_en_valid", {31'd0, out_valid}, 32'd1);
        chk("re_en_bcd",   {24'd0, out_bcd},   32'h00);

`ifdef BCD_CNT_GRAY_OUT_EN
        out_ready = 1'b1; load = 1'b1; load_value = 8'h00; dir = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("gray_tab", {24'd0, out_gray}, {28'd0, gray_tab[k]});
            tick();
        end
`endif

        // Randomised traffic against the model.
        repeat (3000) begin
            en         = ($urandom_range(0, 3) != 0);
            dir        = 1'($urandom_range(0, 1));
            load       = ($urandom_range(0, 9) == 0);
            load_value = 8'($urandom);
            out_ready  = ($urandom_range(0, 9) < 7);
            reset      = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; en = 1'b0; load = 1'b0; out_ready = 1'b1;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_counter_stage.md
# bcd_counter_stage

Multi-digit BCD up/down counter with a valid/ready output handshake. It sits directly upstream of the BCD-to-Gray converter and feeds it one legal BCD word (every digit 0–9) per accepted beat. It supports parallel load, direction control, wrap-around with a terminal-count flag, and backpressure hold. Illegal digits never reach the downstream stage.

## Interface
- `DIGITS`, default 1: number of decade digits; range 1–8.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `en` input 1: count enable; beats are produced only while high.
- `dir` input 1: 1 = count up, 0 = count down; sampled at each handshake.
- `load` input 1: parallel-load request.
- `load_value` input 4*DIGITS: BCD word to load; digit 0 is in bits [3:0].
- `load_ready` output 1: a load is honoured this cycle.
- `out_valid` output 1: `out_bcd` holds a beat.
- `out_ready` input 1: downstream accepts the beat.
- `out_bcd` output 4*DIGITS: current count; every nibble is in 0–9.
- `out_tc` output 1: terminal-count flag, qualified by `out_valid`.
- `err` output 1: sticky; set by a load containing a digit greater than 9.

## Operation
- Reset values:
  - `out_valid` = 0, `out_bcd` = 0, `out_tc` = 0, `err` = 0.
  - Internal count = 0; state = IDLE.
- States:
  - IDLE: `out_valid` = 0.
  - EMIT: `out_valid` = 1.
- Transitions:
  - IDLE → EMIT when `en` = 1.
  - EMIT → IDLE on a handshake (`out_valid && out_ready`) with `en` = 0.
  - EMIT stays in EMIT on a handshake with `en` = 1, or while `out_ready` = 0.
- Hold rule: while `out_valid && !out_ready`, `out_bcd`, `out_tc` and the count are frozen. Deasserting `en` does not drop `out_valid`.
- Step on handshake:
  - `dir` = 1: increment the count; digit 9 → 0 carries into the next digit.
  - `dir` = 0: decrement the count; digit 0 → 9 borrows from the next digit.
  - Each digit is a separate mod-10 cell; binary arithmetic on the whole word is not permitted.
- Wrap-around:
  - Up from all-9s gives all-0s.
  - Down from all-0s gives all-9s.
- `out_tc` is 1 when the presented word is all-9s and `dir` = 1, or all-0s and `dir` = 0.
- `load_ready` = !(`out_valid && !out_ready`).
- Load behaviour:
  - `load && load_ready` sets the count to `load_value`; the next presented beat shows the loaded value.
  - Load has priority over a simultaneous step; the step is discarded.
  - `load` while `load_ready` = 0 is ignored, with no queueing.
- Illegal load digit (greater than 9): that digit is replaced by 0, legal digits load normally, and `err` sets. `err` stays set until reset.
- Reset mid-beat: the pending beat is dropped and no handshake is owed.

## Timing
- Enable latency: `en` rising at cycle N gives `out_valid` = 1 at N+1, with `out_bcd` = current count.
- Step latency: handshake at cycle M gives the next value on `out_bcd` at M+1. Throughput is one beat per cycle with `out_ready` held high.
- Load at cycle L gives the loaded value on `out_bcd` at L+1 (if `en`).
- `load_ready` is combinational from `out_valid` and `out_ready`.
- `out_tc` is registered and aligned with `out_bcd`.
- `err` is registered and asserts the cycle after the offending load.
- No other combinational input-to-output path exists.

## Configuration
- Macro: `BCD_CNT_GRAY_OUT_EN`.
- Defined:
  - Adds output `out_gray` (4*DIGITS bits).
  - Each nibble is its `out_bcd` nibble ^ (that nibble >> 1).
  - Registered, same timing and hold rules as `out_bcd`.
  - Resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `bcd_pkg` holds:
  - `bcd_digit_t` (4-bit logic).
  - `BCD_MAX` = 4'd9.
  - State enum `bcd_cnt_state_e` {IDLE, EMIT}.
  - Function `bcd_to_gray_nib`.
- Sub-module `bcd_digit_cell`:
  - One decade, with inputs `inc`, `dec`, `load`, `din`.
  - Outputs `q`, `carry` and `borrow`.
  - Instantiated DIGITS times in a generate loop, with carry/borrow chained from digit 0 upward.

## Test plan
- Reset, then `en` = 1, `dir` = 1, `out_ready` = 1, DIGITS = 2: beats 00, 01, … 09, 10, … 99, 00. `out_tc` is 1 only on 99.
- Load 4'h0 with `dir` = 0, DIGITS = 1: beats 0, 9, 8. `out_tc` is 1 on the 0 beat.
- Hold `out_ready` = 0 for 3 cycles while presenting 37: `out_bcd` stays 37, `load_ready` = 0, and a load of 55 is ignored. After release, the next beat is 38.
- Load 8'hA5 (DIGITS = 2): next beat is 05 and `err` = 1 until reset. Load of 8'h42 with a simultaneous handshake: next beat is 42, not the stepped value.
- Assert `reset` while `out_valid` = 1 at 63: next cycle `out_valid` = 0 and `out_bcd` = 0. Re-enable: the first beat is 00.
- With `BCD_CNT_GRAY_OUT_EN`: beats 0–9 produce `out_gray` 0, 1, 3, 2, 6, 7, 5, 4, C, D, aligned with `out_bcd`.
